pll_drp_reconfig: RTL and testbench

PLL_DRP_RECONFIG -- requirements
Module: pll_drp_reconfig

---
 rtl/pll_drp_reconfig.sv | 193 +++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig: applies a table of read-modify-write DRP accesses to an
// MMCM. The MMCM is held in reset while the table is applied, and the block
// then waits for lock. Ends with a one-cycle done pulse and a status code.
module pll_drp_reconfig #(
  parameter int NUM_ENTRIES  = 32,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tbl_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   tbl_idx,
  input  logic [6:0]                       tbl_addr,
  input  logic [15:0]                      tbl_mask,
  input  logic [15:0]                      tbl_data,
  input  logic [$clog2(NUM_ENTRIES+1)-1:0] num_entries,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       err_code,
  output logic [63:0]                      reconfig_to_pll,
  input  logic [63:0]                      reconfig_from_pll
);

  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int NUM_W       = $clog2(NUM_ENTRIES + 1);
  localparam int TMAX        = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_W       = $clog2(TMAX + 1);
  // Lock indication is unreliable right after the MMCM leaves reset.
  localparam int LOCK_IGNORE = 4;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_DRDY  = 2'b01;
  localparam logic [1:0] ERR_LOCK  = 2'b10;
  localparam logic [1:0] ERR_COUNT = 2'b11;

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, RELEASE, LOCK_WAIT, FINISH
  } state_t;

  logic [6:0]  addr_tbl [NUM_ENTRIES];
  logic [15:0] mask_tbl [NUM_ENTRIES];
  logic [15:0] data_tbl [NUM_ENTRIES];

  state_t            state_q, state_d;
  logic [NUM_W-1:0]  idx_q, idx_d, count_q, count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       din_d, din_q;
  logic [6:0]        daddr_q;
  logic              den_q, dwe_q, mmcm_rst_q, busy_q, done_q;

  logic [15:0]       dout;
  logic              drdy, locked;
  logic [IDX_W-1:0]  cur_ent, nxt_ent;
  logic              unused_from_pll;

  assign dout            = reconfig_from_pll[15:0];
  assign drdy            = reconfig_from_pll[16];
  assign locked          = reconfig_from_pll[17];
  assign unused_from_pll = &{1'b0, reconfig_from_pll[63:18]};
  assign cur_ent         = idx_q[IDX_W-1:0];
  assign nxt_ent         = idx_d[IDX_W-1:0];

  // Register table: loaded by the host only while no update is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        addr_tbl[i] <= '0;
        mask_tbl[i] <= '0;
        data_tbl[i] <= '0;
      end
    end else if (tbl_we && !busy_q) begin
      addr_tbl[tbl_idx] <= tbl_addr;
      mask_tbl[tbl_idx] <= tbl_mask;
      data_tbl[tbl_idx] <= tbl_data;
    end
  end

  // Next-state logic, entry sequencing, timeout counting and status.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    din_d   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_entries == '0 || num_entries > NUM_W'(NUM_ENTRIES)) begin
            state_d = FINISH;
            err_d   = ERR_COUNT;
          end else begin
            state_d = ASSERT_RST;
            count_d = num_entries;
            idx_d   = '0;
            err_d   = ERR_OK;
          end
        end
      end
      ASSERT_RST: state_d = RD_REQ;
      RD_REQ: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        if (drdy) begin
          state_d = WR_REQ;
          // Keep read bits where mask is set, take new bits elsewhere.
          din_d   = (dout & mask_tbl[cur_ent]) | (data_tbl[cur_ent] & ~mask_tbl[cur_ent]);
        end else if (cnt_q == CNT_W'(DRDY_TIMEOUT)) begin
          state_d = FINISH;
          err_d   = ERR_DRDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_REQ: begin
        state_d = WR_WAIT;
        cnt_d   = '0;
      end
      WR_WAIT: begin
        if (drdy) begin
          state_d = NEXT;
        end else if (cnt_q == CNT_W'(DRDY_TIMEOUT)) begin
          state_d = FINISH;
          err_d   = ERR_DRDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NEXT: begin
        idx_d   = idx_q + NUM_W'(1);
        state_d = (idx_q + NUM_W'(1) == count_q) ? RELEASE : RD_REQ;
      end
      RELEASE: begin
        state_d = LOCK_WAIT;
        cnt_d   = '0;
      end
      LOCK_WAIT: begin
        if (cnt_q >= CNT_W'(LOCK_IGNORE) && locked) begin
          state_d = FINISH;
          err_d   = ERR_OK;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = FINISH;
          err_d   = ERR_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus DRP/status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      err_q      <= ERR_OK;
      din_q      <= '0;
      daddr_q    <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      mmcm_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      din_q      <= din_d;
      daddr_q    <= (state_d == RD_REQ || state_d == WR_REQ) ? addr_tbl[nxt_ent] : 7'd0;
      den_q      <= (state_d == RD_REQ || state_d == WR_REQ);
      dwe_q      <= (state_d == WR_REQ);
      mmcm_rst_q <= state_d inside {ASSERT_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT};
      busy_q     <= (state_d != IDLE && state_d != FINISH);
      done_q     <= (state_d == FINISH);
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_code        = err_q;
  assign reconfig_to_pll = {37'd0, clk, mmcm_rst_q, dwe_q, den_q, daddr_q, din_q};

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: DRP slave/MMCM model, directed updates, and a
// scoreboard of expected DRP accesses and done pulses checked by a monitor.
module tb_pll_drp_reconfig;

  localparam int NE = 8;
  localparam int DT = 8;
  localparam int LT = 20;

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2;
  localparam int R_NONE = 0, R_DEN = 1, R_FALL = 2, R_START = 3;

  logic        clk;
  logic        rst_n;
  logic        tbl_we;
  logic [2:0]  tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_mask;
  logic [15:0] tbl_data;
  logic [3:0]  num_entries;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [63:0] to_pll;
  logic [63:0] from_pll;

  logic        drdy_m;
  logic [15:0] dout_m;
  logic        lock_ok;
  logic        mute;
  int          dly;

  // The MMCM model only reports lock while it is out of reset.
  assign from_pll = {46'd0, lock_ok & ~to_pll[25], drdy_m, dout_m};

  pll_drp_reconfig #(
    .NUM_ENTRIES (NE),
    .DRDY_TIMEOUT(DT),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tbl_we           (tbl_we),
    .tbl_idx          (tbl_idx),
    .tbl_addr         (tbl_addr),
    .tbl_mask         (tbl_mask),
    .tbl_data         (tbl_data),
    .num_entries      (num_entries),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .err_code         (err_code),
    .reconfig_to_pll  (to_pll),
    .reconfig_from_pll(from_pll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int addr;
    int din;
    int err;
    int ref_sel;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   last_den = 0, last_fall = 0, last_start = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push(input int kind, input int addr, input int din,
                               input int err, input int rsel, input int gap);
    exp_t e;
    e.kind = kind; e.addr = addr; e.din = din;
    e.err = err; e.ref_sel = rsel; e.gap = gap;
    sb.push_back(e);
  endfunction

  // Monitor: every DRP strobe cycle and every done pulse pops one expectation.
  initial begin
    logic prev25;
    int   act_kind;
    exp_t e;
    prev25 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start) last_start = cyc;
        if (prev25 && !to_pll[25]) last_fall = cyc;
        prev25 = to_pll[25];
        if (to_pll[23] || done) begin
          act_kind = done ? K_DONE : (to_pll[24] ? K_WR : K_RD);
          if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", act_kind, cyc);
          end else begin
            e = sb.pop_front();
            check("event_kind", act_kind, e.kind);
            if (act_kind != K_DONE) begin
              check("daddr", int'(to_pll[22:16]), e.addr);
              check("mmcm_rst_at_den", int'(to_pll[25]), 1);
              if (act_kind == K_WR) check("din", int'(to_pll[15:0]), e.din);
            end else begin
              check("err_code", int'(err_code), e.err);
              check("busy_at_done", int'(busy), 0);
            end
            if (e.ref_sel == R_DEN)   check("gap_from_den", cyc - last_den, e.gap);
            if (e.ref_sel == R_FALL)  check("gap_from_release", cyc - last_fall, e.gap);
            if (e.ref_sel == R_START) check("gap_from_start", cyc - last_start, e.gap);
          end
          if (to_pll[23]) last_den = cyc;
          if (done) done_cnt++;
        end
      end else begin
        prev25 = 1'b0;
      end
    end
  end

  // DRP slave: register file answering each strobe after dly cycles.
  initial begin
    logic [15:0] mem [128];
    logic [6:0]  a;
    logic [15:0] rv;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[7'h08] = 16'h1234;
    mem[7'h10] = 16'h5555;
    mem[7'h4F] = 16'hA5A5;
    mem[7'h21] = 16'hCAFE;
    drdy_m = 1'b0;
    dout_m = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && to_pll[23]) begin
        a  = to_pll[22:16];
        rv = mem[a];
        if (to_pll[24]) mem[a] = to_pll[15:0];
        if (!mute) begin
          repeat (dly) @(posedge clk);
          #1;
          drdy_m = 1'b1;
          dout_m = rv;
          @(posedge clk);
          #1;
          drdy_m = 1'b0;
        end
      end
    end
  end

  task automatic twrite(input int idx, input int addr, input int mask, input int data);
    @(posedge clk);
    #1;
    tbl_we = 1'b1; tbl_idx = 3'(idx); tbl_addr = 7'(addr);
    tbl_mask = 16'(mask); tbl_data = 16'(data);
    @(posedge clk);
    #1;
    tbl_we = 1'b0;
  endtask

  task automatic go(input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    num_entries = 4'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == c0) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse", limit);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_mask = '0;
    tbl_data = '0; num_entries = '0; start = 1'b0;
    lock_ok = 1'b1; mute = 1'b0; dly = 2;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err_code), 0);
    check("reset_outputs", int'(to_pll[25:0]), 0);
    rst_n = 1'b1;

    // Single entry: 0x1234 masked with 0x1000, new bits 0x0145 -> 0x1145.
    twrite(0, 'h08, 'h1000, 'h0145);
    push(K_RD, 'h08, 0, 0, R_NONE, 0);
    push(K_WR, 'h08, 'h1145, 0, R_DEN, 3);
    push(K_DONE, 0, 0, 0, R_FALL, 6);
    go(1);
    check("busy_after_start", int'(busy), 1);
    wait_done(200);

    // Three entries in index order; entry 2 written in the start cycle;
    // a start plus table write issued while busy must both be ignored.
    dly = 1;
    twrite(0, 'h08, 'hFF00, 'h00AB);
    twrite(1, 'h10, 'h0000, 'hBEEF);
    push(K_RD, 'h08, 0, 0, R_NONE, 0);
    push(K_WR, 'h08, 'h11AB, 0, R_DEN, 2);
    push(K_RD, 'h10, 0, 0, R_NONE, 0);
    push(K_WR, 'h10, 'hBEEF, 0, R_DEN, 2);
    push(K_RD, 'h4F, 0, 0, R_NONE, 0);
    push(K_WR, 'h4F, 'hA5A5, 0, R_DEN, 2);
    push(K_DONE, 0, 0, 0, R_FALL, 6);
    @(posedge clk);
    #1;
    tbl_we = 1'b1; tbl_idx = 3'd2; tbl_addr = 7'h4F; tbl_mask = 16'hFFFF; tbl_data = 16'h0000;
    start = 1'b1; num_entries = 4'd3;
    @(posedge clk);
    #1;
    tbl_we = 1'b0; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; num_entries = 4'd1;
    tbl_we = 1'b1; tbl_idx = 3'd0; tbl_addr = 7'h33; tbl_mask = 16'h0000; tbl_data = 16'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; tbl_we = 1'b0;
    wait_done(300);

    // No drdy on entry 0: done DT+2 cycles after the read strobe, reset dropped.
    mute = 1'b1;
    push(K_RD, 'h08, 0, 0, R_NONE, 0);
    push(K_DONE, 0, 0, 1, R_DEN, DT + 2);
    go(1);
    wait_done(100);
    #1;
    check("mmcm_rst_after_drdy_timeout", int'(to_pll[25]), 0);
    mute = 1'b0;

    // Lock never comes: done LT+1 cycles after the reset release.
    lock_ok = 1'b0;
    push(K_RD, 'h08, 0, 0, R_NONE, 0);
    push(K_WR, 'h08, 'h11AB, 0, R_DEN, 2);
    push(K_DONE, 0, 0, 2, R_FALL, LT + 1);
    go(1);
    wait_done(200);
    lock_ok = 1'b1;

    // Bad counts: zero and above the table depth.
    push(K_DONE, 0, 0, 3, R_START, 1);
    go(0);
    wait_done(20);
    push(K_DONE, 0, 0, 3, R_START, 1);
    go(9);
    wait_done(20);
    repeat (3) @(posedge clk);
    #1;
    check("err_held_after_done", int'(err_code), 3);

    // Reset in WR_WAIT aborts silently; a fresh update then runs to completion.
    dly = 4;
    twrite(0, 'h21, 'h0F0F, 'h1234);
    push(K_RD, 'h21, 0, 0, R_NONE, 0);
    push(K_WR, 'h21, 'h1A3E, 0, R_DEN, 5);
    go(1);
    n = 0;
    while (!to_pll[24] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      checks++;
      errs++;
      $display("FAIL write_strobe_timeout: got no write strobe expected one");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err_code), 0);
    check("abort_outputs", int'(to_pll[25:0]), 0);
    check("abort_pending_events", sb.size(), 0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dly = 2;
    twrite(0, 'h21, 'hFF00, 'h0077);
    push(K_RD, 'h21, 0, 0, R_NONE, 0);
    push(K_WR, 'h21, 'h1A77, 0, R_DEN, 3);
    push(K_DONE, 0, 0, 0, R_FALL, 6);
    go(1);
    wait_done(200);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
